// File: rtl/key_stepper_pkg.sv
// Shared FSM encoding and default 50 MHz timing for the key stepper front-end.
// No logic; constants only.
// Not applicable: no flow control.
package key_stepper_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
    localparam int DEFAULT_REPEAT_DELAY    = 25_000_000;  // 500 ms
    localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;  // 200 ms

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bit, with a configurable reset value.
// Latency: 2 clk cycles.
// No flow control.
module sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_stepper.sv
// Debounces an active-low key into a one-cycle step pulse with captured direction;
// auto-repeat while held when KEY_STEPPER_AUTOREPEAT_EN is defined.
// Latency: step one cycle after edge DEBOUNCE_CYCLES+2; no backpressure (step is a pulse).
module key_stepper
    import key_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic dir_in,
    output logic step,
    output logic dir,
    output logic pressed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("key_stepper: illegal timing parameter");
    end

    logic ks;
    logic ds;

    sync2 #(.RESET_VAL(1'b1)) u_sync_key (.clk(clk), .reset(reset), .d(key_n),  .q(ks));
    sync2 #(.RESET_VAL(1'b0)) u_sync_dir (.clk(clk), .reset(reset), .d(dir_in), .q(ds));

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          step_nxt, dir_nxt, pressed_nxt;

`ifdef KEY_STEPPER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    // rep selects the inter-repeat period once the initial delay has elapsed
    logic [RW-1:0] rcnt, rcnt_nxt, rep_last;
    logic          rep, rep_nxt;

    assign rep_last = rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = 1'b0;
        dir_nxt   = dir;
        case (state)
            IDLE: begin
                if (!ks) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (ks) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    step_nxt  = 1'b1;
                    dir_nxt   = ds;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (ks) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
`ifdef KEY_STEPPER_AUTOREPEAT_EN
                else if (rcnt == rep_last) begin
                    step_nxt = 1'b1;
                    dir_nxt  = ds;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (!ks) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pressed_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
    end

`ifdef KEY_STEPPER_AUTOREPEAT_EN
    // A release bounce returns to HELD with rcnt untouched, so repeat timing resumes
    always_comb begin
        rcnt_nxt = rcnt;
        rep_nxt  = rep;
        if (state_nxt == IDLE || (state == PRESS_WAIT && state_nxt == HELD)) begin
            rcnt_nxt = '0;
            rep_nxt  = 1'b0;
        end else if (state == HELD && state_nxt == HELD) begin
            if (rcnt == rep_last) begin
                rcnt_nxt = '0;
                rep_nxt  = 1'b1;
            end else begin
                rcnt_nxt = rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt <= '0;
            rep  <= 1'b0;
        end else begin
            rcnt <= rcnt_nxt;
            rep  <= rep_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            pressed <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            step    <= step_nxt;
            dir     <= dir_nxt;
            pressed <= pressed_nxt;
        end
    end

endmodule

// File: tb/tb_key_stepper.sv
// Randomized and directed bench for key_stepper against a run-length reference model.
module tb_key_stepper;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_n = 1'b1;
    logic dir_in = 1'b0;
    logic step, dir, pressed;

    key_stepper #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .dir_in(dir_in),
        .step(step), .dir(dir), .pressed(pressed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: ks/ds are the inputs seen two edges earlier. The debounced level flips
    // once the opposite key level has been seen on DB+1 consecutive edges.
    logic k1, k2, d1, d2;
    logic lvl;
    int   run, held_cnt;
    logic e_step, e_dir;

    task automatic model_edge();
        logic opp, held_before;
        if (reset) begin
            k1 = 1; k2 = 1; d1 = 0; d2 = 0;
            lvl = 0; run = 0; held_cnt = 0;
            e_step = 0; e_dir = 0;
        end else begin
            e_step = 0;
            opp = (k2 == lvl);
            held_before = lvl && (run == 0);
            run = opp ? run + 1 : 0;
            if (run == DB + 1) begin
                lvl = !lvl;
                run = 0;
                held_cnt = 0;
                if (lvl) begin
                    e_step = 1;
                    e_dir  = d2;
                end
            end
`ifdef KEY_STEPPER_AUTOREPEAT_EN
            else if (held_before && !opp) begin
                held_cnt++;
                if (held_cnt >= RD && (held_cnt - RD) % RP == 0) begin
                    e_step = 1;
                    e_dir  = d2;
                end
            end
`endif
            k2 = k1; k1 = key_n;
            d2 = d1; d1 = dir_in;
        end
    endtask

    int edge_n, step_edge, n_steps;
    logic step_dir;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("step", int'(step), int'(e_step));
            check("dir", int'(dir), int'(e_dir));
            check("pressed", int'(pressed), int'(lvl));
            if (step === 1'b1) begin
                n_steps++;
                step_dir = dir;
                if (step_edge < 0) step_edge = edge_n;
            end
            edge_n++;
        end
    endtask

    task automatic mark();
        edge_n = 0; step_edge = -1; n_steps = 0;
    endtask

    initial begin
        #1;
        tick(3);
        check("reset_step", int'(step), 0);
        check("reset_dir", int'(dir), 0);
        check("reset_pressed", int'(pressed), 0);
        reset = 0;
        tick(3);

        // clean press
        key_n = 0; mark();
        tick(20);
        check("clean_step_edge", step_edge, 6);
        check("clean_steps", n_steps, 1);
        key_n = 1; tick(12);

        // press bounce then steady press
        key_n = 0; mark(); tick(3);
        key_n = 1; tick(1);
        check("bounce_no_step", n_steps, 0);
        key_n = 0; mark(); tick(12);
        check("bounce_step_edge", step_edge, 6);
        check("bounce_steps", n_steps, 1);

        // release bounce while held
        key_n = 1; mark(); tick(2);
        key_n = 0; tick(6);
        check("rel_bounce_pressed", int'(pressed), 1);
        check("rel_bounce_steps", n_steps, 0);
        key_n = 1; tick(12);
        check("released", int'(pressed), 0);
        key_n = 0; mark(); tick(10);
        check("repress_steps", n_steps, 1);
        key_n = 1; tick(12);

        // direction capture
        dir_in = 1; tick(3);
        key_n = 0; mark(); tick(8);
        check("dir_at_step", int'(step_dir), 1);
        dir_in = 0; tick(3);
        check("dir_held", int'(dir), 1);
        key_n = 1; tick(12);
        check("dir_idle", int'(dir), 1);
        key_n = 0; mark(); tick(8);
        check("dir_next_press", int'(step_dir), 0);
        key_n = 1; tick(12);

        // reset in PRESS_WAIT with cnt=2, key kept low
        key_n = 0; tick(5);
        reset = 1; tick(1);
        check("rst_mid_step", int'(step), 0);
        check("rst_mid_pressed", int'(pressed), 0);
        reset = 0; mark(); tick(12);
        check("rst_mid_step_edge", step_edge, 6);
        check("rst_mid_steps", n_steps, 1);
        key_n = 1; tick(12);

        // long hold: auto-repeat steps at HELD+10,+13,...,+25
        key_n = 0; mark(); tick(32);
`ifdef KEY_STEPPER_AUTOREPEAT_EN
        check("hold_steps", n_steps, 7);
`else
        check("hold_steps", n_steps, 1);
`endif
        key_n = 1; tick(12);

        // random bursts with occasional resets
        for (int b = 0; b < 300; b++) begin
            key_n  = 1'($urandom_range(0, 1));
            dir_in = 1'($urandom_range(0, 1));
            reset  = ($urandom_range(0, 39) == 0);
            tick(reset ? 1 : $urandom_range(1, 14));
            reset = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
